// File: rtl/lfsr_descrambler_pkg.sv
// lfsr_descrambler_pkg: shared LFSR constants and FSM states for the scrambler/descrambler pair
// Contents: LFSR_W, tap positions (x^7 + x^4 + 1), default seed, frame state enum.
package lfsr_descrambler_pkg;
    localparam int LFSR_W = 7;
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 3;
    localparam logic [LFSR_W-1:0] SEED_DEF = 7'h7F;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/lfsr_descrambler_if.sv
// lfsr_descrambler_if: seed control plus input/output valid-ready byte streams
// slave modport = descrambler side, master modport = driver/sink side.
// DESCRAMBLER_PARITY_EN adds s_par (input even parity) and m_par_err (output parity error).
interface lfsr_descrambler_if;
    import lfsr_descrambler_pkg::*;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_data;
    logic              m_last;
`ifdef DESCRAMBLER_PARITY_EN
    logic              s_par;
    logic              m_par_err;
    modport slave (input seed_load, seed_in, s_valid, s_data, s_last, m_ready, s_par,
                   output s_ready, m_valid, m_data, m_last, m_par_err);
    modport master (output seed_load, seed_in, s_valid, s_data, s_last, m_ready, s_par,
                    input s_ready, m_valid, m_data, m_last, m_par_err);
`else
    modport slave (input seed_load, seed_in, s_valid, s_data, s_last, m_ready,
                   output s_ready, m_valid, m_data, m_last);
    modport master (output seed_load, seed_in, s_valid, s_data, s_last, m_ready,
                    input s_ready, m_valid, m_data, m_last);
`endif
endinterface

// File: rtl/lfsr_descrambler_step.sv
// lfsr_byte_step: advances the x^7 + x^4 + 1 Fibonacci LFSR 8 steps, yielding the byte keystream
// Ports: cur (current state), nxt (state after 8 steps), ks (keystream, bit k = step k, LSB first).
module lfsr_byte_step
    import lfsr_descrambler_pkg::*;
(
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt,
    output logic [7:0]        ks
);
    always_comb begin
        nxt = cur;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            ks[i] = nxt[TAP_HI] ^ nxt[TAP_LO];
            nxt = {nxt[LFSR_W-2:0], ks[i]};
        end
    end
endmodule

// File: rtl/lfsr_descrambler.sv
// lfsr_descrambler: XORs each accepted byte with the per-frame LFSR keystream, one register stage
// Ports: clk, rst (sync, active-high), bus (lfsr_descrambler_if.slave: seed control, s_* in, m_* out).
// Option: DESCRAMBLER_PARITY_EN registers m_par_err = parity(descrambled byte) ^ s_par.
module lfsr_descrambler #(
    parameter int         DATA_W   = 8,
    parameter logic [6:0] SEED_DEF = lfsr_descrambler_pkg::SEED_DEF
) (
    input logic                clk,
    input logic                rst,
    lfsr_descrambler_if.slave  bus
);
    import lfsr_descrambler_pkg::*;
    state_t            state, state_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_step;
    logic [DATA_W-1:0] ks;
    logic              accept;
    lfsr_byte_step u_step (.cur(lfsr), .nxt(lfsr_step), .ks(ks));
    // seed_load blocks acceptance so a colliding beat uses the new keystream later
    always_comb begin
        bus.s_ready = (state == RUN) && !bus.seed_load && (!bus.m_valid || bus.m_ready);
        accept = bus.s_valid && bus.s_ready;
        state_nxt = bus.seed_load ? RUN : (accept && bus.s_last) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_DEF;
            bus.m_valid <= 1'b0;
            bus.m_data <= '0;
            bus.m_last <= 1'b0;
        end else begin
            if (bus.seed_load) lfsr <= (bus.seed_in == '0) ? SEED_DEF : bus.seed_in;
            else if (accept) lfsr <= lfsr_step;
            if (accept) begin
                bus.m_data <= bus.s_data ^ ks;
                bus.m_last <= bus.s_last;
            end
            bus.m_valid <= accept || (bus.m_valid && !bus.m_ready);
        end
    end
`ifdef DESCRAMBLER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) bus.m_par_err <= 1'b0;
        else if (accept) bus.m_par_err <= ^(bus.s_data ^ ks) ^ bus.s_par;
    end
`endif
endmodule

// File: tb/tb_lfsr_descrambler.sv
// tb_lfsr_descrambler: directed and randomized self-checking bench for lfsr_descrambler
module tb_lfsr_descrambler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    lfsr_descrambler_if bif ();
    lfsr_descrambler dut (.clk(clk), .rst(rst), .bus(bif));
    always #5 clk = ~clk;

    // reference keystream as the bit sequence b[n+7] = b[n] ^ b[n+3], seeded with s[6]..s[0]
    bit kb[$];
    int kpos;
    function automatic void model_seed(input logic [6:0] seed);
        logic [6:0] s;
        s = (seed == 7'h00) ? 7'h7F : seed;
        kb.delete();
        for (int i = 6; i >= 0; i--) kb.push_back(s[i]);
        kpos = 0;
    endfunction
    function automatic logic [7:0] model_byte();
        logic [7:0] k;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = 7 + kpos + i;
            while (kb.size() <= n) kb.push_back(kb[kb.size()-7] ^ kb[kb.size()-4]);
            k[i] = kb[n];
        end
        kpos += 8;
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bif.seed_load = 1'b0;
        bif.seed_in = 7'h00;
        bif.s_valid = 1'b0;
        bif.s_data = 8'h00;
        bif.s_last = 1'b0;
        bif.m_ready = 1'b1;
`ifdef DESCRAMBLER_PARITY_EN
        bif.s_par = 1'b0;
`endif
    endtask
    task automatic load(input logic [6:0] seed);
        bif.seed_load = 1'b1;
        bif.seed_in = seed;
        step();
        bif.seed_load = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bif.s_valid = 1'b1;
        rst = 1'b1;
        step();
        step();
        checks++; if (bif.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bif.m_valid); end
        checks++; if (bif.m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %h want 00", bif.m_data); end
        checks++; if (bif.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", bif.m_last); end
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bif.s_ready); end
        rst = 1'b0;
        step();
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b want 0", bif.s_ready); end
        bif.s_valid = 1'b0;
    endtask

    task automatic test_basic();
        idle();
        bif.seed_load = 1'b1;
        bif.seed_in = 7'h7F;
        #1;
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL seed_blocks_ready: got %b want 0", bif.s_ready); end
        step();
        bif.seed_load = 1'b0;
        bif.s_valid = 1'b1;
        #1;
        checks++; if (bif.s_ready !== 1'b1) begin errors++; $display("FAIL run_s_ready: got %b want 1", bif.s_ready); end
        step();
        checks++; if (bif.m_valid !== 1'b1) begin errors++; $display("FAIL basic_v0: got %b want 1", bif.m_valid); end
        checks++; if (bif.m_data !== 8'h70) begin errors++; $display("FAIL basic_d0: got %h want 70", bif.m_data); end
        checks++; if (bif.m_last !== 1'b0) begin errors++; $display("FAIL basic_l0: got %b want 0", bif.m_last); end
        bif.s_last = 1'b1;
        step();
        checks++; if (bif.m_data !== 8'h4F) begin errors++; $display("FAIL basic_d1: got %h want 4f", bif.m_data); end
        checks++; if (bif.m_last !== 1'b1) begin errors++; $display("FAIL basic_l1: got %b want 1", bif.m_last); end
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", bif.s_ready); end
        bif.s_valid = 1'b0;
        step();
        checks++; if (bif.m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", bif.m_valid); end
    endtask

    task automatic test_zero_seed();
        idle();
        load(7'h00);
        bif.s_valid = 1'b1;
        bif.s_data = 8'h70;
        bif.s_last = 1'b1;
        step();
        checks++; if (bif.m_data !== 8'h00) begin errors++; $display("FAIL zero_seed: got %h want 00", bif.m_data); end
        bif.s_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        idle();
        load(7'h7F);
        bif.s_valid = 1'b1;
        step();
        bif.m_ready = 1'b0;
        bif.s_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, bif.s_ready); end
            checks++; if (bif.m_valid !== 1'b1 || bif.m_data !== 8'h70) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=70", i, bif.m_valid, bif.m_data); end
            step();
        end
        bif.m_ready = 1'b1;
        #1;
        checks++; if (bif.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", bif.s_ready); end
        step();
        checks++; if (bif.m_data !== 8'h4F || bif.m_last !== 1'b1) begin errors++; $display("FAIL bp_d1: got d=%h l=%b want d=4f l=1", bif.m_data, bif.m_last); end
        bif.s_valid = 1'b0;
        step();
        checks++; if (bif.m_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got %b want 0", bif.m_valid); end
    endtask

    task automatic test_abort();
        idle();
        load(7'h7F);
        bif.s_valid = 1'b1;
        step();
        bif.seed_load = 1'b1;
        bif.seed_in = 7'h7F;
        #1;
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", bif.s_ready); end
        step();
        checks++; if (bif.m_valid !== 1'b0) begin errors++; $display("FAIL abort_noaccept: got %b want 0", bif.m_valid); end
        bif.seed_load = 1'b0;
        step();
        checks++; if (bif.m_valid !== 1'b1 || bif.m_data !== 8'h70) begin errors++; $display("FAIL abort_restart: got v=%b d=%h want v=1 d=70", bif.m_valid, bif.m_data); end
        bif.s_last = 1'b1;
        step();
        bif.s_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        load(7'h7F);
        bif.s_valid = 1'b1;
        bif.m_ready = 1'b0;
        step();
        checks++; if (bif.m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pend: got %b want 1", bif.m_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bif.m_ready = 1'b1;
        #1;
        checks++; if (bif.m_valid !== 1'b0 || bif.m_data !== 8'h00) begin errors++; $display("FAIL rmid_clear: got v=%b d=%h want v=0 d=00", bif.m_valid, bif.m_data); end
        checks++; if (bif.s_ready !== 1'b0) begin errors++; $display("FAIL rmid_idle0: got %b want 0", bif.s_ready); end
        step();
        checks++; if (bif.s_ready !== 1'b0 || bif.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle1: got r=%b v=%b want r=0 v=0", bif.s_ready, bif.m_valid); end
        bif.s_valid = 1'b0;
    endtask

`ifdef DESCRAMBLER_PARITY_EN
    task automatic test_parity();
        idle();
        load(7'h7F);
        bif.s_valid = 1'b1;
        bif.s_data = 8'h70;
        bif.s_last = 1'b1;
        step();
        checks++; if (bif.m_data !== 8'h00 || bif.m_par_err !== 1'b0) begin errors++; $display("FAIL par_ok: got d=%h e=%b want d=00 e=0", bif.m_data, bif.m_par_err); end
        bif.s_valid = 1'b0;
        load(7'h7F);
        bif.s_valid = 1'b1;
        bif.s_par = 1'b1;
        step();
        checks++; if (bif.m_par_err !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", bif.m_par_err); end
        bif.s_valid = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        bit run, mv, ml, mp, acc, exp_ready;
        logic [7:0] md;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 0; mv = 0; ml = 0; mp = 0; md = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            bif.seed_load = ($urandom_range(0, 19) == 0);
            bif.seed_in = ($urandom_range(0, 5) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
            bif.s_valid = ($urandom_range(0, 3) != 0);
            bif.s_data = 8'($urandom);
            bif.s_last = ($urandom_range(0, 6) == 0);
            bif.m_ready = ($urandom_range(0, 3) != 0);
`ifdef DESCRAMBLER_PARITY_EN
            bif.s_par = 1'($urandom);
`endif
            #1;
            exp_ready = run && !bif.seed_load && (!mv || bif.m_ready);
            checks++; if (bif.s_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bif.s_ready, exp_ready); end
            checks++; if (bif.m_valid !== mv) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bif.m_valid, mv); end
            if (mv) begin
                checks++; if (bif.m_data !== md || bif.m_last !== ml) begin errors++; $display("FAIL rnd_data c%0d: got d=%h l=%b want d=%h l=%b", c, bif.m_data, bif.m_last, md, ml); end
`ifdef DESCRAMBLER_PARITY_EN
                checks++; if (bif.m_par_err !== mp) begin errors++; $display("FAIL rnd_par c%0d: got %b want %b", c, bif.m_par_err, mp); end
`endif
            end
            acc = bif.s_valid && exp_ready;
            if (bif.seed_load) begin
                model_seed(bif.seed_in);
                run = 1;
            end else if (acc) begin
                md = bif.s_data ^ model_byte();
                ml = bif.s_last;
`ifdef DESCRAMBLER_PARITY_EN
                mp = (^md) ^ bif.s_par;
`endif
                if (bif.s_last) run = 0;
            end
            mv = acc || (mv && !bif.m_ready);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_zero_seed();
        test_backpressure();
        test_abort();
        test_reset_mid();
`ifdef DESCRAMBLER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
